// File: rtl/sim_io_responder_if.sv
// ----------------------------------------------------------------------------
// sim_io_responder_if
//   Bundles the CPU I/O-window access signals and the host-side TX/RX byte
//   streams of the simulation I/O responder into one interface.
//
//   Signals
//     io_en, io_sel[2:0], io_wr, io_din[7:0]   CPU access strobe / select / data
//     io_dout[7:0]                              read data, one cycle after strobe
//     io_full                                   TX near-full back-pressure
//     program_finish, exit_code[7:0]            sticky exit flag and exit byte
//     tx_data[7:0], tx_valid, tx_ready          TX stream towards the host
//     rx_data[7:0], rx_valid, rx_ready          RX stream from the host
//
//   Modports
//     master  : CPU + host side (drives strobes, tx_ready, rx stream)
//     slave   : the responder itself
// ----------------------------------------------------------------------------
interface sim_io_responder_if;
  logic       io_en;
  logic [2:0] io_sel;
  logic       io_wr;
  logic [7:0] io_din;
  logic [7:0] io_dout;
  logic       io_full;
  logic       program_finish;
  logic [7:0] exit_code;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output io_en, io_sel, io_wr, io_din, tx_ready, rx_data, rx_valid,
    input  io_dout, io_full, program_finish, exit_code, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  io_en, io_sel, io_wr, io_din, tx_ready, rx_data, rx_valid,
    output io_dout, io_full, program_finish, exit_code, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/sim_io_responder.sv
// ----------------------------------------------------------------------------
// sim_io_responder
//   Simulation stand-in for the UART host interface behind the CPU's I/O
//   window. CPU writes to sel0 are buffered in a TX FIFO that drains to the
//   host; CPU reads of sel0 pop bytes the host pushed into an RX FIFO; a write
//   to sel4 raises the sticky program_finish flag and latches the exit code,
//   after which CPU accesses are ignored until reset.
//
//   Register map (io_sel)
//     W0 push TX byte        R0 pop RX byte (8'h00 if empty)
//     W4 exit(code)          R1 {5'b0, tx_empty, tx_overflow, rx_nonempty}
//     R4..R7 cycle counter bytes (only with SIM_IO_CYCLE_COUNT_EN), else 8'h00
//
//   Optional feature macro: SIM_IO_CYCLE_COUNT_EN
//     Adds a 32-bit free-running cycle counter. Reading sel4 snapshots it and
//     returns byte0; sel5/6/7 return bytes 1/2/3 of the last snapshot.
//
//   Ports
//     clk  system clock
//     rst  synchronous reset, active-high
//     bus  sim_io_responder_if.slave (CPU access + host TX/RX streams)
//
//   Parameters
//     TX_DEPTH     TX FIFO entries (power of 2, >=4)
//     RX_DEPTH     RX FIFO entries (power of 2, >=2)
//     FULL_MARGIN  io_full asserts at TX_DEPTH-FULL_MARGIN entries
// ----------------------------------------------------------------------------
module sim_io_responder #(
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic                clk,
  input  logic                rst,
  sim_io_responder_if.slave   bus
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_PW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_PW = RX_AW + 1;
  localparam logic [TX_PW-1:0] TX_FULL_LEVEL = TX_PW'(TX_DEPTH - FULL_MARGIN);

  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [7:0]       tx_mem_d [TX_DEPTH];
  logic [TX_PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [7:0]       rx_mem_d [RX_DEPTH];
  logic [RX_PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic             tx_overflow_q, tx_overflow_d;
  logic             finish_q, finish_d;
  logic [7:0]       exit_code_q, exit_code_d;
  logic [7:0]       dout_q, dout_d;
`ifdef SIM_IO_CYCLE_COUNT_EN
  logic [31:0]      cycle_q, cycle_d;
  logic [31:0]      snap_q, snap_d;
`endif

  logic [TX_PW-1:0] tx_count;
  logic             tx_empty, tx_full, rx_empty, rx_full;
  logic             cpu_wr, cpu_rd;
  logic             tx_push, tx_pop, rx_push, rx_pop;

  // FIFO status from the registered pointers. The extra pointer MSB tells a
  // full FIFO (MSBs differ, index bits equal) apart from an empty one.
  always_comb begin
    tx_count = tx_wr_q - tx_rd_q;
    tx_empty = (tx_wr_q == tx_rd_q);
    tx_full  = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
               (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);
    rx_empty = (rx_wr_q == rx_rd_q);
    rx_full  = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
               (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);
  end

  // Access decode. Once the exit write has landed every CPU access is
  // ignored, but the host-side streams keep moving. A push into a full TX
  // FIFO is dropped even if the host pops in the same cycle.
  always_comb begin
    cpu_wr  = bus.io_en && !finish_q && bus.io_wr;
    cpu_rd  = bus.io_en && !finish_q && !bus.io_wr;
    tx_push = cpu_wr && (bus.io_sel == 3'd0) && !tx_full;
    tx_pop  = !tx_empty && bus.tx_ready;
    rx_push = bus.rx_valid && !rx_full;
    rx_pop  = cpu_rd && (bus.io_sel == 3'd0) && !rx_empty;
  end

  // FIFO next-state: storage writes and pointer advances.
  always_comb begin
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    if (tx_push) begin
      tx_mem_d[tx_wr_q[TX_AW-1:0]] = bus.io_din;
      tx_wr_d = tx_wr_q + 1'b1;
    end
    if (tx_pop) begin
      tx_rd_d = tx_rd_q + 1'b1;
    end
    if (rx_push) begin
      rx_mem_d[rx_wr_q[RX_AW-1:0]] = bus.rx_data;
      rx_wr_d = rx_wr_q + 1'b1;
    end
    if (rx_pop) begin
      rx_rd_d = rx_rd_q + 1'b1;
    end
  end

  // Control registers and the read-data mux. io_dout only changes on a read,
  // so it holds the last returned byte otherwise.
  always_comb begin
    tx_overflow_d = tx_overflow_q;
    finish_d      = finish_q;
    exit_code_d   = exit_code_q;
    dout_d        = dout_q;
`ifdef SIM_IO_CYCLE_COUNT_EN
    cycle_d       = cycle_q + 32'd1;
    snap_d        = snap_q;
`endif
    if (cpu_wr) begin
      if ((bus.io_sel == 3'd0) && tx_full) begin
        tx_overflow_d = 1'b1;
      end
      if (bus.io_sel == 3'd4) begin
        finish_d    = 1'b1;
        exit_code_d = bus.io_din;
      end
    end
    if (cpu_rd) begin
      case (bus.io_sel)
        3'd0: dout_d = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q[RX_AW-1:0]];
        3'd1: dout_d = {5'b0, tx_empty, tx_overflow_q, !rx_empty};
`ifdef SIM_IO_CYCLE_COUNT_EN
        3'd4: begin
          dout_d = cycle_q[7:0];
          snap_d = cycle_q;
        end
        3'd5: dout_d = snap_q[15:8];
        3'd6: dout_d = snap_q[23:16];
        3'd7: dout_d = snap_q[31:24];
`endif
        default: dout_d = 8'h00;
      endcase
    end
  end

  // State registers; reset returns everything, including in-flight read
  // data and FIFO contents, to the idle state on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_mem_q      <= '{default: 8'h00};
      rx_mem_q      <= '{default: 8'h00};
      tx_wr_q       <= '0;
      tx_rd_q       <= '0;
      rx_wr_q       <= '0;
      rx_rd_q       <= '0;
      tx_overflow_q <= 1'b0;
      finish_q      <= 1'b0;
      exit_code_q   <= 8'h00;
      dout_q        <= 8'h00;
`ifdef SIM_IO_CYCLE_COUNT_EN
      cycle_q       <= 32'd0;
      snap_q        <= 32'd0;
`endif
    end else begin
      tx_mem_q      <= tx_mem_d;
      rx_mem_q      <= rx_mem_d;
      tx_wr_q       <= tx_wr_d;
      tx_rd_q       <= tx_rd_d;
      rx_wr_q       <= rx_wr_d;
      rx_rd_q       <= rx_rd_d;
      tx_overflow_q <= tx_overflow_d;
      finish_q      <= finish_d;
      exit_code_q   <= exit_code_d;
      dout_q        <= dout_d;
`ifdef SIM_IO_CYCLE_COUNT_EN
      cycle_q       <= cycle_d;
      snap_q        <= snap_d;
`endif
    end
  end

  // Outputs: io_full is a threshold on the registered count so the CPU store
  // pipeline has FULL_MARGIN slots of slack before bytes start dropping.
  always_comb begin
    bus.io_dout        = dout_q;
    bus.io_full        = (tx_count >= TX_FULL_LEVEL);
    bus.program_finish = finish_q;
    bus.exit_code      = exit_code_q;
    bus.tx_data        = tx_mem_q[tx_rd_q[TX_AW-1:0]];
    bus.tx_valid       = !tx_empty;
    bus.rx_ready       = !rx_full;
  end

endmodule
